// File: rtl/clk_reg_pkg.sv
// Shared constants, phase type and increment clamp for the NCO clock regulator.
// Imported by the channel and top modules.
package clk_reg_pkg;

  localparam int ACC_W_DEF       = 32;
  localparam int LOCK_CYCLES_DEF = 16;

  typedef logic [ACC_W_DEF-1:0] phase_t;

  // 100 MHz refclk -> 48 MHz enable rate
  localparam phase_t INC_48M_FROM_100M = 32'h7AE1_47AE;

  localparam phase_t INC_MAX = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Highest usable rate is refclk/2
  function automatic phase_t clamp_inc(input phase_t inc);
    return (inc > INC_MAX) ? INC_MAX : inc;
  endfunction

endpackage

// File: rtl/clk_reg_nco_ch.sv
// One NCO channel: accumulator, shadow increment with pending flag, pulse/square regs.
// Ports: clk, rst_n, enable, wr/wr_inc (accepted write), clk_en, clk_out, pending, inc_nz.
module clk_reg_nco_ch
  import clk_reg_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             clk_en,
  output logic             clk_out,
  output logic             pending,
  output logic             inc_nz
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  assign sum    = {1'b0, acc} + {1'b0, inc};
  assign carry  = enable & sum[ACC_W];
  assign inc_nz = |inc;

  // Swap on the wrap edge so the phase stays continuous; an idle
  // or frozen channel has no wrap to wait for, so swap at once.
  // A write landing on a wrap edge sees pending=0 here, so it
  // waits for the following wrap.
  assign apply = pending & (carry | ~enable | ~inc_nz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      inc     <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      clk_en  <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (enable) begin
        acc     <= sum[ACC_W-1:0];
        clk_out <= acc[ACC_W-1];
      end
      clk_en <= carry;
      if (apply) begin
        inc     <= shadow;
        pending <= 1'b0;
      end else if (wr) begin
        shadow  <= wr_inc;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_regulator_nco.sv
// Multi-channel NCO clock-enable generator with run-time ratio updates and lock flag.
// Ports: refclk, rst_n, enable, cfg_valid/ready/ch/inc, clk_en, clk_out, locked.
module clk_regulator_nco
  import clk_reg_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_CYCLES);
  localparam logic [ACC_W-1:0] INC_LIM = {1'b1, {(ACC_W-1){1'b0}}};

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] inc_nz;
  logic [NUM_CH-1:0] wr;
  logic [ACC_W-1:0]  inc_clamped;
  logic              sel_pend;
  logic              accept;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign inc_clamped = (cfg_inc > INC_LIM) ? INC_LIM : cfg_inc;

  // Out-of-range channels never pend, so they are always accepted
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pend = pending[i];
    end
  end

  assign cfg_ready = rst_n & ~sel_pend;
  assign accept    = cfg_valid & cfg_ready;

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = accept & (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_reg_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk     (refclk),
      .rst_n   (rst_n),
      .enable  (enable),
      .wr      (wr[g]),
      .wr_inc  (inc_clamped),
      .clk_en  (clk_en[g]),
      .clk_out (clk_out[g]),
      .pending (pending[g]),
      .inc_nz  (inc_nz[g])
    );
  end

  always_comb begin
    cnt_nxt = cnt;
    if (accept | ~enable | ~|inc_nz) begin
      cnt_nxt = '0;
    end else if (~|pending && cnt != LOCK_N) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      locked <= (cnt_nxt == LOCK_N);
    end
  end

endmodule

// File: tb/tb_clk_regulator_nco.sv
// Directed self-checking bench for clk_regulator_nco.
// Reset, rate, stall, wrap-aligned update, 48 MHz ratio, lock and clamp.
module tb_clk_regulator_nco;
  import clk_reg_pkg::*;

  logic        refclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_inc = '0;
  logic        cfg_ready;
  logic [2:0]  clk_en;
  logic [2:0]  clk_out;
  logic        locked;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  clk_regulator_nco #(
    .NUM_CH      (3),
    .ACC_W       (32),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .clk_en    (clk_en),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic write_cfg(input logic [1:0] ch,
                           input logic [31:0] inc);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses[$];
    int exp_p[6] = '{8, 24, 40, 56, 60, 64};
    int rdy_edge;
    bit rdy_seen;
    int n48;
    int last;
    int imin;
    int imax;
    logic [2:0] en_acc;

    // Reset state while held
    #12;
    chk("rst_clk_en", 32'(clk_en), 0);
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(cfg_ready), 1);
    chk("rel_locked", 32'(locked), 0);

    // Quarter-rate channel 0, lock after 16 stable edges
    write_cfg(2'd0, 32'h4000_0000);
    chk("pend_ready0", 32'(cfg_ready), 0);
    tick();
    chk("applied_ready0", 32'(cfg_ready), 1);
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("q_en_%0d", k), 32'(clk_en[0]), 32'(k % 4 == 0));
      chk($sformatf("q_out_%0d", k), 32'(clk_out[0]),
          32'((k - 1) % 4 >= 2));
      if (k == 15) chk("lock_15", 32'(locked), 0);
      if (k == 16) chk("lock_16", 32'(locked), 1);
    end

    // Freeze drops lock, holds square wave, forces no pulse
    enable = 1'b0;
    tick();
    chk("frz_locked", 32'(locked), 0);
    chk("frz_en", 32'(clk_en), 0);
    chk("frz_out0", 32'(clk_out[0]), 1);
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_out0", 32'(clk_out[0]), 1);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(clk_en), 0);
    chk("arst_out", 32'(clk_out), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_ready", 32'(cfg_ready), 0);
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    chk("arel_ready", 32'(cfg_ready), 1);
    chk("arel_locked", 32'(locked), 0);
    en_acc = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      en_acc |= clk_en | clk_out;
    end
    chk("arel_no_pulse", 32'(en_acc), 0);

    // Stall of second write, wrap-aligned updates, ch0 unaffected
    write_cfg(2'd1, 32'h2000_0000);
    tick();
    write_cfg(2'd1, 32'h1000_0000);
    #1;
    chk("stall_ch1", 32'(cfg_ready), 0);
    cfg_ch = 2'd0;
    #1;
    chk("ready_ch0", 32'(cfg_ready), 1);
    write_cfg(2'd0, INC_48M_FROM_100M);
    cfg_ch = 2'd1;
    rdy_seen = 1'b0;
    rdy_edge = 0;
    for (int k = 3; k <= 66; k++) begin
      if (k == 40) begin
        cfg_valid = 1'b1;
        cfg_inc   = 32'h4000_0000;
      end
      tick();
      cfg_valid = 1'b0;
      if (!rdy_seen && cfg_ready) begin
        rdy_seen = 1'b1;
        rdy_edge = k;
      end
      if (k == 41) chk("stall_at_wrap", 32'(cfg_ready), 0);
      if (clk_en[1]) pulses.push_back(k);
    end
    chk("stall_release_edge", 32'(rdy_edge), 8);
    chk("ch1_pulse_count", 32'(pulses.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pulses.size())
        chk($sformatf("ch1_pulse_%0d", i), 32'(pulses[i]), 32'(exp_p[i]));
    end

    // 48 MHz from 100 MHz over 10000 cycles
    n48  = 0;
    last = -1;
    imin = 1000;
    imax = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (clk_en[0]) begin
        n48++;
        if (last >= 0) begin
          if (c - last < imin) imin = c - last;
          if (c - last > imax) imax = c - last;
        end
        last = c;
      end
    end
    chk("nco48_count_ok", 32'(n48 == 4799 || n48 == 4800), 1);
    chk("nco48_min_gap", 32'(imin), 2);
    chk("nco48_max_gap", 32'(imax), 3);
    chk("long_run_locked", 32'(locked), 1);

    // Accept to an unused channel still restarts lock
    write_cfg(2'd3, 32'h0000_1234);
    chk("ign_locked", 32'(locked), 0);
    chk("ign_ready", 32'(cfg_ready), 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("relock_15", 32'(locked), 0);
      if (k == 16) chk("relock_16", 32'(locked), 1);
    end

    // Clamp: all-ones becomes half rate on channel 2
    write_cfg(2'd2, 32'hFFFF_FFFF);
    chk("clamp_pend", 32'(cfg_ready), 0);
    tick();
    chk("clamp_applied", 32'(cfg_ready), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("clamp_en_%0d", k), 32'(clk_en[2]), 32'(k % 2 == 0));
      chk($sformatf("clamp_out_%0d", k), 32'(clk_out[2]), 32'(k % 2 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
